// File: rtl/clk_polarity_ctrl_pkg.sv
// Shared types for the clock polarity sequencer.
// State encodings and small elaboration helpers.
package clk_polarity_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_SWITCH  = 2'd2,
    ST_RESTART = 2'd3
  } cpc_state_e;

  function automatic int cpc_max(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_polarity_ctrl_settle.sv
// settle_timer: loadable down-counter with a zero flag.
// Holds at zero; the owner reloads before it could wrap.
module settle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/clk_polarity_ctrl.sv
// Polarity-change sequencer for a clkxor stage.
// Gates the branch off around every select flip.
module clk_polarity_ctrl
  import clk_polarity_ctrl_pkg::*;
#(
  parameter logic RESET_POL     = 1'b0,
  parameter int   GATE_CYCLES   = 4,
  parameter int   SWITCH_CYCLES = 4,
  parameter int   W_CTR         =
    $clog2(cpc_max(GATE_CYCLES, SWITCH_CYCLES)) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_pol,
  output logic req_ready,
  output logic done,
  output logic busy,
  output logic xor_sel,
  output logic clk_en
);

  localparam logic [W_CTR-1:0] G_LD =
    W_CTR'(GATE_CYCLES - 1);
  localparam logic [W_CTR-1:0] S_LD =
    W_CTR'(SWITCH_CYCLES - 1);

  cpc_state_e       state_q, state_d;
  logic             xor_q, xor_d;
  logic             clk_en_q, clk_en_d;
  logic             done_q, done_d;
  logic             ld;
  logic [W_CTR-1:0] ld_val;
  logic             dec;
  logic             zero;

  settle_timer #(
    .W (W_CTR)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .load_val (ld_val),
    .dec      (dec),
    .zero     (zero)
  );

  always_comb begin
    state_d  = state_q;
    xor_d    = xor_q;
    clk_en_d = clk_en_q;
    done_d   = 1'b0;
    ld       = 1'b0;
    ld_val   = '0;
    dec      = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (req_valid) begin
          if (req_pol == xor_q) begin
            done_d = 1'b1;
          end else begin
            state_d  = ST_DRAIN;
            clk_en_d = 1'b0;
            ld       = 1'b1;
            ld_val   = G_LD;
          end
        end
      end
      (state_q == ST_DRAIN): begin
        if (zero) begin
          xor_d   = ~xor_q;
          ld      = 1'b1;
          ld_val  = S_LD;
          state_d = ST_SWITCH;
        end else begin
          dec = 1'b1;
        end
      end
      (state_q == ST_SWITCH): begin
        if (zero) begin
          clk_en_d = 1'b1;
          ld       = 1'b1;
          ld_val   = G_LD;
          state_d  = ST_RESTART;
        end else begin
          dec = 1'b1;
        end
      end
      (state_q == ST_RESTART): begin
        if (zero) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      xor_q    <= RESET_POL;
      clk_en_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      xor_q    <= xor_d;
      clk_en_q <= clk_en_d;
      done_q   <= done_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = ~req_ready;
  assign done      = done_q;
  assign xor_sel   = xor_q;
  assign clk_en    = clk_en_q;

endmodule

// File: tb/tb_clk_polarity_ctrl.sv
// Directed bench for clk_polarity_ctrl.
// Default timing plus a G=S=1 instance.
module tb_clk_polarity_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic a_valid = 1'b0, a_pol = 1'b0;
  logic a_ready, a_done, a_busy, a_xor, a_en;
  logic b_valid = 1'b0, b_pol = 1'b0;
  logic b_ready, b_done, b_busy, b_xor, b_en;

  int total = 0;
  int bad = 0;
  int rst_cnt = 0;
  int viol = 0;

  always #5 clk = ~clk;

  clk_polarity_ctrl u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (a_valid),
    .req_pol   (a_pol),
    .req_ready (a_ready),
    .done      (a_done),
    .busy      (a_busy),
    .xor_sel   (a_xor),
    .clk_en    (a_en)
  );

  clk_polarity_ctrl #(
    .GATE_CYCLES   (1),
    .SWITCH_CYCLES (1)
  ) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (b_valid),
    .req_pol   (b_pol),
    .req_ready (b_ready),
    .done      (b_done),
    .busy      (b_busy),
    .xor_sel   (b_xor),
    .clk_en    (b_en)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  always @(negedge rst_n) rst_cnt++;

  // select must never move unless the gate is off on both sides
  logic pa_x = 1'b0, pa_e = 1'b1;
  logic pb_x = 1'b0, pb_e = 1'b1;
  int   last_rc = 0;
  always @(negedge clk) begin
    if (rst_n && rst_cnt == last_rc) begin
      if (a_xor != pa_x && (a_en || pa_e)) viol++;
      if (b_xor != pb_x && (b_en || pb_e)) viol++;
    end
    pa_x = a_xor; pa_e = a_en;
    pb_x = b_xor; pb_e = b_en;
    last_rc = rst_cnt;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(
    input string tag,
    input logic  x,
    input logic  e,
    input logic  d,
    input logic  b
  );
    chk({tag, ".xor"}, 32'(a_xor), 32'(x));
    chk({tag, ".en"}, 32'(a_en), 32'(e));
    chk({tag, ".done"}, 32'(a_done), 32'(d));
    chk({tag, ".busy"}, 32'(a_busy), 32'(b));
    chk({tag, ".rdy"}, 32'(a_ready), 32'(!b));
  endtask

  initial begin
    #12;
    chk_a("rst", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst1.en", 32'(b_en), 32'd1);
    #10 rst_n = 1'b1;
    step();
    chk_a("idle", 1'b0, 1'b1, 1'b0, 1'b0);

    // change to 1 with default timing
    a_valid = 1'b1; a_pol = 1'b1;
    step();
    a_valid = 1'b0;
    chk_a("chg.e0", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      step();
      chk_a($sformatf("chg.e%0d", k),
            k >= 4, k >= 8, k == 12, k < 12);
    end

    // no-op request, then back-to-back no-ops
    a_valid = 1'b1; a_pol = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_a($sformatf("noop%0d", k),
            1'b1, 1'b1, 1'b1, 1'b0);
    end
    a_valid = 1'b0;
    step();
    chk_a("noop.end", 1'b1, 1'b1, 1'b0, 1'b0);

    // held valid with toggling pol; retaken in done cycle
    a_valid = 1'b1; a_pol = 1'b0;
    step();
    chk_a("hold.e0", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      a_pol = ~k[0];
      step();
      chk_a($sformatf("hold.e%0d", k),
            k < 4, k >= 8, k == 12, k < 12);
    end
    step();
    a_valid = 1'b0;
    chk_a("hold.re", 1'b0, 1'b0, 1'b0, 1'b1);

    // async reset at E6 of the retaken sequence
    for (int k = 1; k <= 6; k++) step();
    chk_a("mid.e6", 1'b1, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_a("mid.rst", 1'b0, 1'b1, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    step();
    chk_a("post.idle", 1'b0, 1'b1, 1'b0, 1'b0);
    a_valid = 1'b1; a_pol = 1'b1;
    step();
    a_valid = 1'b0;
    for (int k = 1; k <= 12; k++) step();
    chk_a("post.e12", 1'b1, 1'b1, 1'b1, 1'b0);

    // G=S=1 instance: done after E3
    b_valid = 1'b1; b_pol = 1'b1;
    step();
    b_valid = 1'b0;
    chk("g1.e0.en", 32'(b_en), 32'd0);
    chk("g1.e0.x", 32'(b_xor), 32'd0);
    step();
    chk("g1.e1.en", 32'(b_en), 32'd0);
    chk("g1.e1.x", 32'(b_xor), 32'd1);
    step();
    chk("g1.e2.en", 32'(b_en), 32'd1);
    chk("g1.e2.done", 32'(b_done), 32'd0);
    chk("g1.e2.busy", 32'(b_busy), 32'd1);
    step();
    chk("g1.e3.done", 32'(b_done), 32'd1);
    chk("g1.e3.busy", 32'(b_busy), 32'd0);
    step();
    chk("g1.e4.done", 32'(b_done), 32'd0);

    step();
    chk("order.viol", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
